enet_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single Ethernet TX engine among `NUM_REQ` packet sources. Each source uses the same request/ready/complete handshake it would use against the engine directly. The arbiter grants one source at a time and forwards its data words and the engine's ready strobe. It holds the grant until the engine reports completion, or until a completion timeout expires. It sits between the packet generators (demo, ARP responder, UDP sender) and the TX engine.

---
 rtl/enet_tx_arbiter_pkg.sv | 25 ++
 rtl/enet_tx_arbiter_if.sv | 36 +++
 rtl/enet_tx_arbiter_rr_priority_pick.sv | 34 +++
 rtl/enet_tx_arbiter.sv | 133 +++++++++++++
 tb/tb_enet_tx_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/enet_tx_arbiter_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | enet_tx_pkg: shared types and helpers for the Ethernet TX arbiter.      |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
package enet_tx_pkg;

  localparam int ENET_WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTIVE    = 2'd1,
    WAIT_CMPL = 2'd2
  } arb_state_e;

  // Round-robin index step with an explicit wrap at n (base < n, step <= n).
  function automatic int rr_wrap(input int base, input int step, input int n);
    int s;
    s = base + step;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/enet_tx_arbiter_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | enet_tx_arbiter_if: source-side and engine-side arbiter signals.        |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
interface enet_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import enet_tx_pkg::*;

  logic [NUM_REQ-1:0]             req_in;
  logic [ENET_WORD_W*NUM_REQ-1:0] data_in;
  logic [NUM_REQ-1:0]             data_rdy_out;
  logic [NUM_REQ-1:0]             complete_out;
  logic [NUM_REQ-1:0]             grant_out;
  logic                           tx_req_out;
  logic [ENET_WORD_W-1:0]         tx_packet_data_out;
  logic                           tx_packet_data_rdy_in;
  logic                           tx_complete_in;
  logic                           timeout_err_out;

  // Sources and engine side (drives the *_in signals).
  modport master (
    output req_in, data_in, tx_packet_data_rdy_in, tx_complete_in,
    input  data_rdy_out, complete_out, grant_out, tx_req_out,
           tx_packet_data_out, timeout_err_out
  );

  // Arbiter side.
  modport slave (
    input  req_in, data_in, tx_packet_data_rdy_in, tx_complete_in,
    output data_rdy_out, complete_out, grant_out, tx_req_out,
           tx_packet_data_out, timeout_err_out
  );
endinterface
`default_nettype wire

// File: rtl/enet_tx_arbiter_rr_priority_pick.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rr_priority_pick: combinational round-robin winner search.              |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module rr_priority_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [IDX_W-1:0]   win_idx,
  output logic               win_valid
);
  import enet_tx_pkg::*;

  // Walk from the farthest candidate to the nearest so that the nearest
  // requester after last_idx is the one left standing.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand      = '0;
    win_idx   = '0;
    win_valid = 1'b0;
    for (int step = NUM_REQ; step >= 1; step--) begin
      cand = IDX_W'(rr_wrap(int'(last_idx), step, NUM_REQ));
      if (req[cand]) begin
        win_idx   = cand;
        win_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/enet_tx_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | enet_tx_arbiter: round-robin share of the Ethernet TX engine.           |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module enet_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             Clock,
  input  logic             Reset,
  enet_tx_arbiter_if.slave bus
);
  import enet_tx_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
  localparam logic [IDX_W-1:0]   LAST_RST = IDX_W'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] complete_q, complete_d;
  logic               timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic                   fwd_req;
  logic [ENET_WORD_W-1:0] fwd_data;
  logic [NUM_REQ-1:0]     fwd_rdy;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req       (bus.req_in),
    .last_idx  (last_grant_q),
    .win_idx   (pick_idx),
    .win_valid (pick_valid)
  );

  always_comb begin
    state_d       = state_q;
    grant_idx_d   = grant_idx_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    complete_d    = '0;
    timeout_err_d = 1'b0;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_idx_d = pick_idx;
          grant_d     = ONE_HOT0 << pick_idx;
          state_d     = ACTIVE;
        end
      end
      ACTIVE: begin
        // No preemption: only the granted source's request matters here.
        if (!bus.req_in[grant_idx_q]) begin
          grant_d = '0;
          cnt_d   = '0;
          state_d = WAIT_CMPL;
        end
      end
      WAIT_CMPL: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        // Completion takes priority over a coincident timeout expiry.
        if (bus.tx_complete_in) begin
          complete_d   = ONE_HOT0 << grant_idx_q;
          last_grant_d = grant_idx_q;
          state_d      = IDLE;
        end else if (cnt_q == CNT_TERM) begin
          timeout_err_d = 1'b1;
          last_grant_d  = grant_idx_q;
          state_d       = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= IDLE;
      grant_idx_q   <= '0;
      last_grant_q  <= LAST_RST;
      grant_q       <= '0;
      complete_q    <= '0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      grant_idx_q   <= grant_idx_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      complete_q    <= complete_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  // Zero-latency forwarding mux, open only while ACTIVE.
  always_comb begin
    fwd_req  = 1'b0;
    fwd_data = '0;
    fwd_rdy  = '0;
    if (state_q == ACTIVE) begin
      fwd_req = bus.req_in[grant_idx_q];
      fwd_rdy = (ONE_HOT0 << grant_idx_q) & {NUM_REQ{bus.tx_packet_data_rdy_in}};
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_idx_q == IDX_W'(i)) fwd_data = bus.data_in[i*ENET_WORD_W +: ENET_WORD_W];
      end
    end
  end

  assign bus.tx_req_out         = fwd_req;
  assign bus.tx_packet_data_out = fwd_data;
  assign bus.data_rdy_out       = fwd_rdy;
  assign bus.grant_out          = grant_q;
  assign bus.complete_out       = complete_q;
  assign bus.timeout_err_out    = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_enet_tx_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_enet_tx_arbiter: vector table, directed corners, random vs. model.   |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_enet_tx_arbiter;

  localparam int NREQ = 2;
  localparam int T0   = 32;   // u_dut0: long enough for a 20-cycle completion
  localparam int T1   = 8;    // u_dut1: short timeout for abort corners

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [1:0]  req   = '0;
  logic [31:0] data  = '0;
  logic        rdy   = 1'b0;
  logic        cmpl  = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  enet_tx_arbiter_if #(.NUM_REQ(NREQ)) bus0 ();
  enet_tx_arbiter_if #(.NUM_REQ(NREQ)) bus1 ();

  assign bus0.req_in = req;  assign bus0.data_in = data;
  assign bus0.tx_packet_data_rdy_in = rdy;  assign bus0.tx_complete_in = cmpl;
  assign bus1.req_in = req;  assign bus1.data_in = data;
  assign bus1.tx_packet_data_rdy_in = rdy;  assign bus1.tx_complete_in = cmpl;

  enet_tx_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(T0)) u_dut0 (
    .Clock (Clock), .Reset (Reset), .bus (bus0)
  );
  enet_tx_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(T1)) u_dut1 (
    .Clock (Clock), .Reset (Reset), .bus (bus1)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] data;
    logic        rdy;
    logic        cmpl;
    logic        exp_txreq;
    logic [15:0] exp_data;
    logic [1:0]  exp_rdy;
  } vec_t;
  vec_t tbl [6];

  // Abstract reference: who owns the engine, whether it is draining.
  int m_owner, m_drain, m_wait, m_last, m_cpulse, m_tpulse;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [1:0] r, input logic [31:0] d, input logic rd, input logic cm);
    @(negedge Clock);
    req = r; data = d; rdy = rd; cmpl = cm;
    #1;
  endtask

  task automatic reset_dut();
    @(negedge Clock);
    Reset = 1'b1; req = '0; data = 32'hFFFF_FFFF; rdy = 1'b1; cmpl = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    #1;
  endtask

  task automatic model_reset();
    m_owner = -1; m_drain = 0; m_wait = 0; m_last = NREQ - 1; m_cpulse = -1; m_tpulse = 0;
  endtask

  task automatic model_step();
    m_cpulse = -1; m_tpulse = 0;
    if (Reset) begin
      model_reset();
    end else if (m_owner < 0) begin
      for (int s = 1; s <= NREQ; s++) begin
        if (m_owner < 0 && req[(m_last + s) % NREQ]) begin
          m_owner = (m_last + s) % NREQ;
          m_drain = 0;
        end
      end
    end else if (m_drain == 0) begin
      if (!req[m_owner]) begin m_drain = 1; m_wait = 0; end
    end else if (cmpl) begin
      m_cpulse = m_owner; m_last = m_owner; m_owner = -1;
    end else if (m_wait == T0 - 1) begin
      m_tpulse = 1; m_last = m_owner; m_owner = -1;
    end else begin
      m_wait++;
    end
  endtask

  initial begin
    tbl[0] = '{2'b01, 32'hFFFF_1234, 1'b1, 1'b0, 1'b1, 16'h1234, 2'b01};
    tbl[1] = '{2'b11, 32'h5555_0000, 1'b0, 1'b0, 1'b1, 16'h0000, 2'b00};
    tbl[2] = '{2'b11, 32'h0001_BEEF, 1'b1, 1'b1, 1'b1, 16'hBEEF, 2'b01};
    tbl[3] = '{2'b01, 32'hAAAA_FFFF, 1'b0, 1'b1, 1'b1, 16'hFFFF, 2'b00};
    tbl[4] = '{2'b11, 32'h7FFE_8001, 1'b1, 1'b0, 1'b1, 16'h8001, 2'b01};
    tbl[5] = '{2'b01, 32'h0F0F_F0F0, 1'b1, 1'b0, 1'b1, 16'hF0F0, 2'b01};

    // Reset state, with live-looking inputs that must stay blocked.
    reset_dut();
    chk("rst_grant",   bus0.grant_out, 0);
    chk("rst_txreq",   bus0.tx_req_out, 0);
    chk("rst_data",    bus0.tx_packet_data_out, 0);
    chk("rst_rdy",     bus0.data_rdy_out, 0);
    chk("rst_cmpl",    bus0.complete_out, 0);
    chk("rst_to",      bus1.timeout_err_out, 0);

    // Table: forwarding while source 0 is ACTIVE, incl. stray completions.
    cyc(2'b01, 32'h0, 1'b0, 1'b0);
    chk("tbl_idle_grant", bus0.grant_out, 0);
    foreach (tbl[i]) begin
      cyc(tbl[i].req, tbl[i].data, tbl[i].rdy, tbl[i].cmpl);
      chk($sformatf("tbl%0d_grant", i), bus0.grant_out, 2'b01);
      chk($sformatf("tbl%0d_txreq", i), bus0.tx_req_out, tbl[i].exp_txreq);
      chk($sformatf("tbl%0d_data", i),  bus0.tx_packet_data_out, tbl[i].exp_data);
      chk($sformatf("tbl%0d_rdy", i),   bus0.data_rdy_out, tbl[i].exp_rdy);
      chk($sformatf("tbl%0d_cmpl", i),  bus0.complete_out, 0);
    end

    // Single source: 13 words, ready every 2nd cycle, completion 20 later.
    begin
      int words, pulses, other, bad_data;
      words = 0; pulses = 0; other = 0; bad_data = 0;
      reset_dut();
      cyc(2'b01, 32'h0, 1'b0, 1'b0);
      chk("ss_idle_grant", bus0.grant_out, 0);
      for (int k = 0; k < 60 && words < 13; k++) begin
        cyc(2'b01, {16'h5A5A, 16'(16'hA000 + words)}, k[0], 1'b0);
        if (k == 0) chk("ss_grant", bus0.grant_out, 2'b01);
        if (bus0.tx_packet_data_out !== 16'(16'hA000 + words) || bus0.tx_req_out !== 1'b1)
          bad_data++;
        if (bus0.data_rdy_out[0] === 1'b1) pulses++;
        if (bus0.data_rdy_out[1] !== 1'b0) other++;
        if (rdy) words++;
      end
      cyc(2'b00, 32'h5A5A_0000, 1'b1, 1'b0);
      chk("ss_drop_txreq", bus0.tx_req_out, 0);
      for (int k = 1; k < 20; k++) begin
        cyc(2'b00, 32'h5A5A_0000, 1'b1, 1'b0);
        if (bus0.data_rdy_out !== 2'b00 || bus0.complete_out !== 2'b00) other++;
      end
      cyc(2'b00, 32'h0, 1'b0, 1'b1);
      cyc(2'b00, 32'h0, 1'b0, 1'b0);
      chk("ss_cmpl_pulse", bus0.complete_out, 2'b01);
      chk("ss_cmpl_grant", bus0.grant_out, 0);
      cyc(2'b00, 32'h0, 1'b0, 1'b0);
      chk("ss_cmpl_once", bus0.complete_out, 0);
      chk("ss_rdy_pulses", pulses, 13);
      chk("ss_other_rdy", other, 0);
      chk("ss_data", bad_data, 0);
    end

    // Round-robin: grants 0,1,0 with one IDLE cycle between frames.
    reset_dut();
    cyc(2'b11, 32'h2222_1111, 1'b0, 1'b0);
    for (int f = 0; f < 3; f++) begin
      logic [1:0] exp;
      exp = f[0] ? 2'b10 : 2'b01;
      cyc(2'b11, 32'h2222_1111, 1'b0, 1'b0);
      chk($sformatf("rr%0d_grant", f), bus0.grant_out, exp);
      chk($sformatf("rr%0d_data", f), bus0.tx_packet_data_out, f[0] ? 16'h2222 : 16'h1111);
      cyc(2'b11, 32'h2222_1111, 1'b0, 1'b0);
      cyc(2'b11 & ~exp, 32'h2222_1111, 1'b0, 1'b0);
      cyc(2'b11, 32'h2222_1111, 1'b0, 1'b1);
      cyc(2'b11, 32'h2222_1111, 1'b0, 1'b0);
      chk($sformatf("rr%0d_cmpl", f), bus0.complete_out, exp);
      chk($sformatf("rr%0d_idle", f), bus0.grant_out, 0);
    end

    // Timeout on source 1 (u_dut1).
    reset_dut();
    cyc(2'b10, 32'h0, 1'b0, 1'b0);
    cyc(2'b10, 32'h0, 1'b0, 1'b0);
    chk("to_grant", bus1.grant_out, 2'b10);
    cyc(2'b00, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      cyc(2'b00, 32'h0, 1'b0, 1'b0);
      chk($sformatf("to_wait%0d", k), {bus1.timeout_err_out, bus1.complete_out}, 0);
    end
    cyc(2'b11, 32'h0, 1'b0, 1'b0);
    chk("to_pulse", bus1.timeout_err_out, 1);
    chk("to_no_cmpl", bus1.complete_out, 0);
    cyc(2'b11, 32'h0, 1'b0, 1'b0);
    chk("to_once", bus1.timeout_err_out, 0);
    chk("to_next_grant", bus1.grant_out, 2'b01);

    // Completion coincides with timeout terminal count (u_dut1).
    reset_dut();
    cyc(2'b01, 32'h0, 1'b0, 1'b0);
    cyc(2'b01, 32'h0, 1'b0, 1'b0);
    cyc(2'b00, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) cyc(2'b00, 32'h0, 1'b0, 1'b0);
    cyc(2'b00, 32'h0, 1'b0, 1'b1);
    cyc(2'b00, 32'h0, 1'b0, 1'b0);
    chk("sim_cmpl", bus1.complete_out, 2'b01);
    chk("sim_no_to", bus1.timeout_err_out, 0);
    cyc(2'b00, 32'h0, 1'b0, 1'b0);
    chk("sim_no_late_to", bus1.timeout_err_out, 0);

    // Reset mid-ACTIVE on source 1.
    reset_dut();
    cyc(2'b10, 32'h1234_5678, 1'b1, 1'b0);
    cyc(2'b10, 32'h1234_5678, 1'b1, 1'b0);
    chk("mr_grant", bus0.grant_out, 2'b10);
    chk("mr_data", bus0.tx_packet_data_out, 16'h1234);
    chk("mr_rdy", bus0.data_rdy_out, 2'b10);
    cyc(2'b11, 32'h1234_5678, 1'b1, 1'b0);
    Reset = 1'b1;
    cyc(2'b11, 32'h1234_5678, 1'b1, 1'b0);
    chk("mr_zero", {bus0.grant_out, bus0.tx_req_out, bus0.tx_packet_data_out,
                    bus0.data_rdy_out, bus0.complete_out, bus0.timeout_err_out}, 0);
    Reset = 1'b0;
    cyc(2'b11, 32'h1234_5678, 1'b1, 1'b0);
    chk("mr_first_grant", bus0.grant_out, 2'b01);

    // Random stimulus against the reference model (u_dut0).
    reset_dut();
    model_reset();
    begin
      logic dead;
      logic [1:0] r;
      dead = 1'b0;
      r = 2'b00;
      for (int n = 0; n < 900; n++) begin
        int act;
        if (n % 150 == 149) dead = ~dead;
        for (int b = 0; b < NREQ; b++) if ($urandom_range(0, 4) == 0) r[b] = ~r[b];
        cyc(r, $urandom, 1'($urandom), !dead && ($urandom_range(0, 5) == 0));
        act = (m_owner >= 0 && m_drain == 0) ? 1 : 0;
        chk("rnd_grant", bus0.grant_out, act != 0 ? (32'd1 << m_owner) : 32'd0);
        chk("rnd_txreq", bus0.tx_req_out, act != 0 ? 32'(req[m_owner]) : 32'd0);
        chk("rnd_data", bus0.tx_packet_data_out, act != 0 ? 32'(data[16*m_owner +: 16]) : 32'd0);
        chk("rnd_rdy", bus0.data_rdy_out, act != 0 ? (32'(rdy) << m_owner) : 32'd0);
        chk("rnd_cmpl", bus0.complete_out, m_cpulse >= 0 ? (32'd1 << m_cpulse) : 32'd0);
        chk("rnd_to", bus0.timeout_err_out, 32'(m_tpulse));
        Reset = ($urandom_range(0, 199) == 0);
        model_step();
      end
      Reset = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
